// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit shared constants and types.
// Fetch FSM encoding and default widths.
package pc_fetch_unit_pkg;

  localparam int          DEF_XLEN       = 32;
  localparam logic [31:0] DEF_RESET_ADDR = 32'h8000_0000;
  localparam int          INSTR_W        = 32;

  typedef logic [0:0] state_t;

  localparam state_t ST_RUN   = 1'b0;
  localparam state_t ST_FAULT = 1'b1;

endpackage

// File: rtl/pc_fetch_unit_fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with async reset and clear.
// Push when full and pop when empty are ignored.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_push  = i_push & (r_cnt != CW'(DEPTH));
  assign w_pop   = i_pop & (r_cnt != '0);
  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= nxt(r_wp);
      if (w_pop)  r_rp <= nxt(r_rp);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clr) r_mem[r_wp] <= i_wdata;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch PC owner, credit-limited imem requester,
// flush/drop tracking and {pc, instr} output stream.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              XLEN            = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_ADDR      = XLEN'(DEF_RESET_ADDR),
  parameter int              COMPRESSED      = 0,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fault_addr,
  output logic [XLEN-1:0] pc
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int OW = XLEN + INSTR_W;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_drop;
  logic            r_fault;
  logic [XLEN-1:0] r_fault_addr;

  logic            w_flush;
  logic            w_mis;
  logic            w_issue;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_aq_addr;
  logic [CW-1:0]   w_aq_cnt;
  logic [CW-1:0]   w_ob_cnt;
  logic [CW:0]     w_credit;
  logic [OW-1:0]   w_ob_data;

  assign w_flush = trap_valid | redirect_valid;
  assign w_tgt   = trap_valid ? trap_pc : redirect_pc;
  assign w_mis   = w_tgt[0] | ((COMPRESSED == 0) & w_tgt[1]);

  // Credits cover both in-flight requests and buffered results.
  assign w_credit = {1'b0, w_aq_cnt} + {1'b0, w_ob_cnt};

  assign imem_req_valid = (r_state == ST_RUN) & ~stall & ~w_flush
                        & (w_credit < (CW+1)'(MAX_OUTSTANDING));
  assign imem_req_addr  = r_pc;
  assign w_issue        = imem_req_valid & imem_req_ready;

  assign w_drop = w_flush | (r_drop != '0);
  assign w_push = imem_rsp_valid & ~w_drop;
  assign w_pop  = out_valid & out_ready & ~w_flush;

  assign out_valid   = (w_ob_cnt != '0);
  assign out_pc      = w_ob_data[OW-1:INSTR_W];
  assign out_instr   = w_ob_data[INSTR_W-1:0];
  assign fetch_fault = r_fault;
  assign fault_addr  = r_fault_addr;
  assign pc          = r_pc;

  fetch_fifo #(.W(XLEN), .DEPTH(MAX_OUTSTANDING)) u_addr_q (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (1'b0),
    .i_push  (w_issue),
    .i_wdata (r_pc),
    .i_pop   (imem_rsp_valid),
    .o_rdata (w_aq_addr),
    .o_count (w_aq_cnt)
  );

  fetch_fifo #(.W(OW), .DEPTH(MAX_OUTSTANDING)) u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_flush),
    .i_push  (w_push),
    .i_wdata ({w_aq_addr, imem_rsp_data}),
    .i_pop   (w_pop),
    .o_rdata (w_ob_data),
    .o_count (w_ob_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_ADDR;
      r_drop       <= '0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_flush) begin
      r_drop  <= w_aq_cnt - CW'(imem_rsp_valid);
      r_pc    <= w_tgt;
      r_fault <= w_mis;
      r_state <= w_mis ? ST_FAULT : ST_RUN;
      if (w_mis) r_fault_addr <= w_tgt;
    end else begin
      if (w_issue) r_pc <= r_pc + XLEN'(4);
      if (imem_rsp_valid && r_drop != '0) r_drop <= r_drop - CW'(1);
    end
  end

  a_no_orphan_rsp: assert property (
    @(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (w_aq_cnt != '0)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit against an epoch-tagged
// fetch-stream model with an in-order latency memory.
module tb_pc_fetch_unit;

  localparam int          MAX = 2;
  localparam logic [31:0] RST = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_fault;
  logic [31:0] fault_addr;
  logic [31:0] pc;

  pc_fetch_unit #(
    .XLEN(32), .RESET_ADDR(RST), .COMPRESSED(0), .MAX_OUTSTANDING(MAX)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .fetch_fault(fetch_fault), .fault_addr(fault_addr), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  bit          m_run;
  bit          m_fault;
  logic [31:0] m_pc;
  logic [31:0] m_faddr;
  int          epoch = 0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = RST + ($urandom_range(0, 63) << 2);
    if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF4;
    if ($urandom_range(0, 3) == 0) t = t + $urandom_range(1, 3);
    return t;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    trap_valid = 1'b0;
    out_ready = 1'b0;
    mem_q.delete();
    exp_q.delete();
    m_run = 1'b1;
    m_fault = 1'b0;
    m_pc = RST;
    m_faddr = '0;
    epoch++;
    #1;
    check("rst_pc", pc, RST);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_fault", 32'(fetch_fault), 0);
    check("rst_fault_addr", fault_addr, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cycle(input int p_st, input int p_rdy, input int p_ordy,
                       input int p_red, input int p_trap);
    bit          e_rv;
    bit          flush;
    bit          mis;
    logic [31:0] tgt;
    mreq_t       h;
    stall          = ($urandom_range(0, 99) < p_st);
    imem_req_ready = ($urandom_range(0, 99) < p_rdy);
    out_ready      = ($urandom_range(0, 99) < p_ordy);
    redirect_valid = ($urandom_range(0, 99) < p_red);
    trap_valid     = ($urandom_range(0, 99) < p_trap);
    redirect_pc    = rand_tgt();
    trap_pc        = rand_tgt();
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    flush = trap_valid | redirect_valid;
    tgt   = trap_valid ? trap_pc : redirect_pc;
    mis   = tgt[0] | tgt[1];
    e_rv  = m_run && !stall && !flush && (mem_q.size() + exp_q.size() < MAX);
    check("req_valid", 32'(imem_req_valid), 32'(e_rv));
    if (e_rv) check("req_addr", imem_req_addr, m_pc);
    check("pc", pc, m_pc);
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_pc", out_pc, exp_q[0]);
      check("out_instr", out_instr, instr_of(exp_q[0]));
    end
    check("fault", 32'(fetch_fault), 32'(m_fault));
    check("fault_addr", fault_addr, m_faddr);
    @(posedge clk);
    if (flush) begin
      if (imem_rsp_valid) void'(mem_q.pop_front());
      epoch++;
      exp_q.delete();
      m_pc    = tgt;
      m_run   = !mis;
      m_fault = mis;
      if (mis) m_faddr = tgt;
    end else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (imem_rsp_valid) begin
        h = mem_q.pop_front();
        if (h.epoch == epoch) exp_q.push_back(h.addr);
      end
      if (e_rv && imem_req_ready) begin
        mem_q.push_back('{m_pc, epoch, cyc + 1 + $urandom_range(0, 2)});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  int ph_st[8]   = '{0,  0,   10, 10, 30, 0,   50, 20};
  int ph_rdy[8]  = '{100, 100, 80, 80, 60, 100, 50, 90};
  int ph_ordy[8] = '{100, 0,   70, 70, 50, 100, 90, 30};
  int ph_red[8]  = '{0,  0,   5,  3,  4,  8,   2,  3};
  int ph_trap[8] = '{0,  0,   0,  3,  2,  0,   1,  3};

  initial begin
    @(negedge clk);
    for (int ph = 0; ph < 8; ph++) begin
      do_reset();
      for (int i = 0; i < 400; i++)
        cycle(ph_st[ph], ph_rdy[ph], ph_ordy[ph], ph_red[ph], ph_trap[ph]);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised successor to the single-register program counter. It owns the hart's fetch PC, issues instruction-memory requests through a valid/ready handshake, and tracks in-flight requests. Redirects and traps flush the fetch path, and stale responses are discarded. It sits between the PC-select logic of the hart and the IF/ID pipeline register, and delivers {pc, instr} pairs through a valid/ready output stream.

Parameters:
XLEN, 32, address/data width in bits.
RESET_ADDR, 32'h8000_0000, PC value loaded on reset; must match hart RESET_ADDR.
COMPRESSED, 0, 1 = 2-byte target alignment legal; 0 = 4-byte alignment required.
MAX_OUTSTANDING, 2, credit limit: issued-but-unconsumed requests (in flight plus buffered); range 1..8.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
stall  input  1  hold: no new request issued while high
redirect_valid  input  1  branch/jump redirect request
redirect_pc  input  XLEN  redirect target
trap_valid  input  1  trap/exception redirect; priority over redirect_valid
trap_pc  input  XLEN  trap vector target
imem_req_valid  output  1  request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  request address
imem_rsp_valid  input  1  response valid; in order, no backpressure
imem_rsp_data  input  32  instruction word
out_valid  output  1  instruction available
out_ready  input  1  downstream accepts
out_pc  output  XLEN  PC of presented instruction
out_instr  output  32  presented instruction
fetch_fault  output  1  misaligned-target fault latched
fault_addr  output  XLEN  offending target address
pc  output  XLEN  next address to be requested (debug/visibility)

Behaviour:
- Reset (async, any cycle including mid-transaction):
  - pc = RESET_ADDR; state = RUN.
  - Outstanding, drop and buffer counts = 0.
  - out_valid = 0, fetch_fault = 0, fault_addr = 0.
- flush = trap_valid | redirect_valid. The target is trap_pc when trap_valid is high, otherwise redirect_pc.
- imem_req_valid = (state == RUN) & ~stall & ~flush & (outstanding + buffered < MAX_OUTSTANDING). It is combinational; imem_req_addr = pc.
- Issue handshake (imem_req_valid & imem_req_ready):
  - pc <= pc + 4, wrapping modulo 2^XLEN.
  - The issued pc is pushed into the address queue; outstanding += 1.
- Response handling:
  - If drop_cnt > 0, the response is discarded and drop_cnt -= 1.
  - Otherwise it is paired with the head of the address queue and pushed into the output buffer (depth MAX_OUTSTANDING).
  - In both cases outstanding -= 1 and the address queue pops.
- Output stream:
  - Output = head of the buffer; out_valid = buffer non-empty.
  - Pop on out_valid & out_ready.
  - Zero-latency bypass is not required: minimum latency is imem_rsp_valid in cycle N → out_valid in N+1.
- Flush cycle:
  - Output buffer cleared, and out_valid is low from the next cycle.
  - drop_cnt <= outstanding − (imem_rsp_valid ? 1 : 0), with any response in the same cycle also discarded. Already-queued addresses are drained with their dropped responses.
  - fetch_fault cleared.
  - If the target is aligned: pc <= target and state <= RUN. The first request to the target goes out in the next cycle.
  - If the target is misaligned (target[0], or target[1] when COMPRESSED = 0): state <= FAULT, fetch_fault <= 1, fault_addr <= target, and pc <= target.
- FAULT state: no requests issued. In-flight responses drain and are dropped. The state exits only on the next flush.
- Stall does not block responses or the output stream, and does not affect drop accounting.
- Simultaneous trap and redirect: the trap wins and the redirect is ignored.
- Simultaneous flush and out_ready: the pop is irrelevant because the buffer is cleared.
- Invariant: outstanding + buffered ≤ MAX_OUTSTANDING. Assert that there is never a response while outstanding == 0.

Decomposition:
- Shared package: XLEN default, RESET_ADDR, instruction width constant, and the state enum {RUN, FAULT}.
- One natural sub-module: fetch_fifo, a parametrised synchronous FIFO (width, depth, async reset, clear input).
  - Instantiated twice: as the address queue (XLEN) and as the output buffer (XLEN + 32).

Test Plan:
1. Reset mid-run, then release with imem_req_ready = 1 and one-cycle response latency → requests 0x8000_0000, 0x8000_0004, 0x8000_0008; out_pc follows in order with matching instr.
2. out_ready = 0 with MAX_OUTSTANDING = 2 → exactly 2 requests issued; imem_req_valid stays low until one out pop.
3. Redirect to 0x8000_0100 while 2 requests are in flight → both responses dropped; next out_pc = 0x8000_0100; no stale instruction appears at the output.
4. trap_valid (trap_pc 0x8000_0040) and redirect_valid (0x8000_0200) in the same cycle → next request is 0x8000_0040.
5. Redirect to 0x8000_0102 with COMPRESSED = 0 → fetch_fault = 1, fault_addr = 0x8000_0102, no requests; a later redirect to 0x8000_0000 clears the fault and resumes fetch.
6. pc = 0xFFFF_FFFC issue → next request 0x0000_0000 (wrap); stall held 3 cycles → no requests, pc unchanged, pending responses still delivered.
